hexn_core: RTL and testbench

- Parametrised successor to the 8-bit hex processor core: same 16-opcode nibble ISA, with prefix/operand register.
- Generalised data width; separate address width.
- Memory is external, reached through a variable-latency req/ack bus (wait states supported), replacing the internal memory array.
- Adds halt (SVC) and a debug view of the A register; the core sits between a memory/peripheral fabric and the system testbench.

---
 rtl/hexn_core.sv | 103 ++++++++++
 tb/tb_hexn_core.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hexn_core.sv
// hexn_core: parametrised nibble-ISA hex processor with external req/ack memory bus
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   mem_req/we/addr/wdata : transfer request, held stable until mem_ack
//   mem_rdata, mem_ack    : read data and completion, sampled together
//   halted, dbg_a         : SVC halt flag and live view of register A
module hexn_core #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          halted,
    output logic [DW-1:0] dbg_a
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;
    state_t state, state_n;
    logic [DW-1:0] a, b, o, a_n, b_n, o_n, pco, aso, bso;
    logic [AW-1:0] pc, pc_n, ma, ma_n;
    logic [3:0] i, i_n;
    logic st;
    assign pco = DW'(pc) + o;
    assign aso = a + o;
    assign bso = b + o;
    assign st = i == 4'h2 || i == 4'h8;
    // reset gates the request combinationally so a pending transfer drops at once
    assign mem_req = !reset && (state == FETCH || state == MEM);
    assign mem_we = state == MEM && st;
    assign mem_addr = state == MEM ? ma : pc;
    assign mem_wdata = a;
    assign halted = state == HALT;
    assign dbg_a = a;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            a <= '0;
            b <= '0;
            o <= '0;
            pc <= '0;
            i <= '0;
            ma <= '0;
        end else begin
            state <= state_n;
            a <= a_n;
            b <= b_n;
            o <= o_n;
            pc <= pc_n;
            i <= i_n;
            ma <= ma_n;
        end
    end
    always_comb begin
        state_n = state;
        a_n = a;
        b_n = b;
        o_n = o;
        pc_n = pc;
        i_n = i;
        ma_n = ma;
        case (state)
            FETCH: if (mem_ack) begin
                i_n = mem_rdata[7:4];
                o_n = o | DW'(mem_rdata[3:0]);
                pc_n = pc + AW'(1);
                state_n = EXEC;
            end
            EXEC: begin
                o_n = '0;
                state_n = FETCH;
                case (i)
                    4'h0, 4'h1, 4'h2: begin ma_n = AW'(o); state_n = MEM; end
                    4'h3: a_n = o;
                    4'h4: b_n = o;
                    4'h5: a_n = pco;
                    4'h6: begin ma_n = AW'(aso); state_n = MEM; end
                    4'h7, 4'h8: begin ma_n = AW'(bso); state_n = MEM; end
                    4'h9: pc_n = AW'(pco);
                    4'hA: pc_n = a == '0 ? AW'(pco) : pc;
                    4'hB: pc_n = a[DW-1] ? AW'(pco) : pc;
                    4'hC: begin
                        pc_n = o == DW'(0) ? AW'(b) : pc;
                        a_n = o == DW'(1) ? a + b : o == DW'(2) ? a - b : a;
                        state_n = o == DW'(3) ? HALT : FETCH;
                    end
                    4'hD: o_n = o << 4;
                    4'hE: o_n = (~o) << 4;
                    default: ;
                endcase
            end
            MEM: if (mem_ack) begin
                a_n = (i == 4'h0 || i == 4'h6) ? mem_rdata : a;
                b_n = (i == 4'h1 || i == 4'h7) ? mem_rdata : b;
                state_n = FETCH;
            end
            HALT: ;
        endcase
    end
endmodule

// File: tb/tb_hexn_core.sv
// tb_hexn_core: directed self-checking bench for hexn_core at DW=8 and DW=16
module tb_hexn_core;
    logic clk = 0;
    always #5 clk = ~clk;
    int checks = 0, fails = 0;

    logic rst8 = 1, req8, we8, ack8, halt8;
    logic [7:0] addr8, wd8, rd8, da8;
    logic [7:0] m8[256], img8[256];
    logic load8 = 0;
    int dly8 = 0, wc8 = 0, unst8 = 0, bad34 = 0, nwr8 = 0;
    logic [7:0] lwa8 = 0, lwd8 = 0, pa8 = 0, pd8 = 0;
    logic pw8 = 0, pend8 = 0;

    logic rst16 = 1, req16, we16, halt16;
    logic [7:0] addr16;
    logic [15:0] wd16, rd16, da16;
    logic [15:0] m16[256];

    logic [15:0] a_at[64], o_at[64];
    logic [7:0] pc_at[64];

    hexn_core #(.DW(8), .AW(8)) u8 (
        .clk(clk), .reset(rst8), .mem_req(req8), .mem_we(we8), .mem_addr(addr8),
        .mem_wdata(wd8), .mem_rdata(rd8), .mem_ack(ack8), .halted(halt8), .dbg_a(da8)
    );
    hexn_core #(.DW(16), .AW(8)) u16 (
        .clk(clk), .reset(rst16), .mem_req(req16), .mem_we(we16), .mem_addr(addr16),
        .mem_wdata(wd16), .mem_rdata(rd16), .mem_ack(req16), .halted(halt16), .dbg_a(da16)
    );

    assign ack8 = req8 && (wc8 >= dly8);
    assign rd8 = m8[addr8];
    assign rd16 = m16[addr16];

    always @(posedge clk) begin
        wc8 <= (req8 && !ack8) ? wc8 + 1 : 0;
        if (load8) m8 <= img8;
        else if (req8 && ack8 && we8) m8[addr8] <= wd8;
        if (req8 && ack8 && we8) begin
            nwr8 <= nwr8 + 1;
            lwa8 <= addr8;
            lwd8 <= wd8;
        end
        if (req8 && ack8 && !we8 && (addr8 == 8'd3 || addr8 == 8'd4)) bad34 <= bad34 + 1;
        if (pend8 && !rst8 && (!req8 || addr8 !== pa8 || we8 !== pw8 || wd8 !== pd8)) unst8 <= unst8 + 1;
        pend8 <= req8 && !ack8;
        pa8 <= addr8;
        pw8 <= we8;
        pd8 <= wd8;
    end

    task automatic boot8(input int d);
        rst8 = 1;
        dly8 = d;
        load8 = 1;
        @(posedge clk);
        #1 load8 = 0;
        @(negedge clk);
        rst8 = 0;
    endtask

    task automatic boot16();
        rst16 = 1;
        @(posedge clk);
        @(negedge clk);
        rst16 = 0;
    endtask

    task automatic run(input bit w, input int maxc, output int hc);
        hc = -1;
        for (int c = 1; c <= maxc && c < 64; c++) begin
            @(posedge clk);
            #1;
            a_at[c] = w ? da16 : {8'h00, da8};
            o_at[c] = w ? u16.o : {8'h00, u8.o};
            pc_at[c] = w ? u16.pc : u8.pc;
            if (w ? halt16 : halt8) begin
                hc = c;
                break;
            end
        end
    endtask

    task automatic prog1();
        foreach (img8[k]) img8[k] = 8'h00;
        img8[0] = 8'hD1;
        img8[1] = 8'h32;
        img8[2] = 8'hC3;
    endtask

    task automatic test_reset();
        prog1();
        boot8(0);
        repeat (4) @(posedge clk);
        #1 dly8 = 100;
        @(posedge clk);
        #1;
        checks++; if (req8 !== 1'b1) begin fails++; $display("FAIL rst_pre_req got=%0h want=1", req8); end
        checks++; if (addr8 !== 8'h02) begin fails++; $display("FAIL rst_pre_addr got=%0h want=2", addr8); end
        #2 rst8 = 1;
        #1;
        checks++; if (req8 !== 1'b0) begin fails++; $display("FAIL rst_req got=%0h want=0", req8); end
        checks++; if (u8.pc !== 8'h00) begin fails++; $display("FAIL rst_pc got=%0h want=0", u8.pc); end
        checks++; if (da8 !== 8'h00) begin fails++; $display("FAIL rst_dbg_a got=%0h want=0", da8); end
        checks++; if (halt8 !== 1'b0) begin fails++; $display("FAIL rst_halted got=%0h want=0", halt8); end
        checks++; if (we8 !== 1'b0 || addr8 !== 8'h00) begin fails++; $display("FAIL rst_bus got=%0h/%0h want=0/0", we8, addr8); end
    endtask

    task automatic test_basic();
        int hc, nreq;
        prog1();
        boot8(0);
        run(0, 40, hc);
        checks++; if (a_at[4] !== 16'h0012) begin fails++; $display("FAIL basic_a4 got=%0h want=12", a_at[4]); end
        checks++; if (hc !== 6) begin fails++; $display("FAIL basic_halt_cycle got=%0d want=6", hc); end
        nreq = 0;
        repeat (6) begin
            @(posedge clk);
            #1 if (req8) nreq++;
        end
        checks++; if (nreq !== 0) begin fails++; $display("FAIL basic_req_after_halt got=%0d want=0", nreq); end
        checks++; if (u8.pc !== 8'h03) begin fails++; $display("FAIL basic_pc got=%0h want=3", u8.pc); end
    endtask

    task automatic test_waits();
        int hc, u0;
        prog1();
        boot8(3);
        u0 = unst8;
        run(0, 40, hc);
        checks++; if (hc !== 15) begin fails++; $display("FAIL wait_halt_cycle got=%0d want=15", hc); end
        checks++; if (da8 !== 8'h12) begin fails++; $display("FAIL wait_a got=%0h want=12", da8); end
        checks++; if (unst8 - u0 !== 0) begin fails++; $display("FAIL wait_stable got=%0d want=0", unst8 - u0); end
        checks++; if (a_at[9] !== 16'h0000) begin fails++; $display("FAIL wait_a9 got=%0h want=0", a_at[9]); end
    endtask

    task automatic test_branch();
        int hc, b0;
        foreach (img8[k]) img8[k] = 8'h00;
        img8[0] = 8'hE0;
        img8[1] = 8'h3F;
        img8[2] = 8'hB2;
        img8[3] = 8'h31;
        img8[4] = 8'h31;
        img8[5] = 8'hC3;
        boot8(0);
        b0 = bad34;
        run(0, 40, hc);
        checks++; if (o_at[2] !== 16'h00F0) begin fails++; $display("FAIL br_nfix_o got=%0h want=f0", o_at[2]); end
        checks++; if (a_at[4] !== 16'h00FF) begin fails++; $display("FAIL br_a got=%0h want=ff", a_at[4]); end
        checks++; if (pc_at[5] !== 8'h03 || pc_at[6] !== 8'h05) begin fails++; $display("FAIL br_pc got=%0h->%0h want=3->5", pc_at[5], pc_at[6]); end
        checks++; if (u8.pc !== 8'h06 || hc !== 8) begin fails++; $display("FAIL br_halt got=pc %0h cyc %0d want=pc 6 cyc 8", u8.pc, hc); end
        checks++; if (bad34 - b0 !== 0) begin fails++; $display("FAIL br_skipped_fetch got=%0d want=0", bad34 - b0); end
        checks++; if (da8 !== 8'hFF) begin fails++; $display("FAIL br_final_a got=%0h want=ff", da8); end
    endtask

    task automatic test_store();
        int hc, w0;
        foreach (img8[k]) img8[k] = 8'h00;
        img8[0] = 8'h35;
        img8[1] = 8'hD2;
        img8[2] = 8'h20;
        img8[3] = 8'hD2;
        img8[4] = 8'h10;
        img8[5] = 8'h33;
        img8[6] = 8'hC1;
        img8[7] = 8'hC3;
        boot8(0);
        w0 = nwr8;
        run(0, 60, hc);
        checks++; if (nwr8 - w0 !== 1) begin fails++; $display("FAIL st_writes got=%0d want=1", nwr8 - w0); end
        checks++; if (lwa8 !== 8'h20 || lwd8 !== 8'h05) begin fails++; $display("FAIL st_write got=%0h:%0h want=20:05", lwa8, lwd8); end
        checks++; if (u8.b !== 8'h05) begin fails++; $display("FAIL st_b got=%0h want=5", u8.b); end
        checks++; if (da8 !== 8'h08) begin fails++; $display("FAIL st_a got=%0h want=8", da8); end
        checks++; if (hc !== 18) begin fails++; $display("FAIL st_halt_cycle got=%0d want=18", hc); end
    endtask

    task automatic test_wide16();
        int hc;
        foreach (m16[k]) m16[k] = 16'h0000;
        m16[0] = 16'h00D1;
        m16[1] = 16'h00D2;
        m16[2] = 16'h00D3;
        m16[3] = 16'h0034;
        m16[4] = 16'h0040;
        m16[5] = 16'h00C1;
        m16[6] = 16'h00C3;
        boot16();
        run(1, 40, hc);
        checks++; if (a_at[8] !== 16'h1234) begin fails++; $display("FAIL w16_ldac got=%0h want=1234", a_at[8]); end
        checks++; if (u16.b !== 16'h0000) begin fails++; $display("FAIL w16_b got=%0h want=0", u16.b); end
        checks++; if (da16 !== 16'h1234 || hc !== 14) begin fails++; $display("FAIL w16_add got=%0h cyc %0d want=1234 cyc 14", da16, hc); end
    endtask

    task automatic test_wrap16();
        int hc;
        foreach (m16[k]) m16[k] = 16'h0000;
        m16[0] = 16'h00E0;
        m16[1] = 16'h003F;
        m16[2] = 16'h0041;
        m16[3] = 16'h00C2;
        m16[4] = 16'h00C1;
        m16[5] = 16'h00C1;
        m16[6] = 16'h00A2;
        m16[7] = 16'h0031;
        m16[8] = 16'h0031;
        m16[9] = 16'h00C3;
        boot16();
        run(1, 40, hc);
        checks++; if (a_at[4] !== 16'hFFFF) begin fails++; $display("FAIL wr_ldac got=%0h want=ffff", a_at[4]); end
        checks++; if (a_at[8] !== 16'hFFFE) begin fails++; $display("FAIL wr_sub got=%0h want=fffe", a_at[8]); end
        checks++; if (a_at[12] !== 16'h0000) begin fails++; $display("FAIL wr_add_wrap got=%0h want=0", a_at[12]); end
        checks++; if (pc_at[14] !== 8'h09) begin fails++; $display("FAIL wr_brz got=%0h want=9", pc_at[14]); end
        checks++; if (u16.pc !== 8'h0A || da16 !== 16'h0000 || hc !== 16) begin fails++; $display("FAIL wr_final got=pc %0h a %0h cyc %0d want=pc a a 0 cyc 16", u16.pc, da16, hc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_waits();
        test_branch();
        test_store();
        test_wide16();
        test_wrap16();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
